// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: parity mode encoding, width limits and entry flag layout.
package uart_tx_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 16;

  // Buffer entries are laid out {active, parity, data}; these are the upper two fields.
  typedef struct packed {
    logic active;
    logic parity;
  } par_flags_t;

endpackage

// File: rtl/tx_parity_engine_if.sv
// Input valid/ready and output valid/ack bundle of the TX parity engine.
interface tx_parity_engine_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int LEN_W = $clog2(DATA_WIDTH + 1);

  logic                  Parity_Enable;
  logic [1:0]            Parity_Mode;
  logic [LEN_W-1:0]      Frame_Len;
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] Parallel_Data;
  logic                  Data_Ready;
  logic                  Out_Valid;
  logic                  Out_Ack;
  logic [DATA_WIDTH-1:0] Out_Data;
  logic                  Parity_Bit;
  logic                  Parity_Active;

  modport slave (
    input  Parity_Enable, Parity_Mode, Frame_Len, Data_Valid, Parallel_Data, Out_Ack,
    output Data_Ready, Out_Valid, Out_Data, Parity_Bit, Parity_Active
  );

  modport master (
    output Parity_Enable, Parity_Mode, Frame_Len, Data_Valid, Parallel_Data, Out_Ack,
    input  Data_Ready, Out_Valid, Out_Data, Parity_Bit, Parity_Active
  );
endinterface

// File: rtl/tx_parity_engine_parity_core.sv
// Combinational masked parity: clamps the frame length, masks the word, derives the parity bit.
module parity_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_WIDTH  = 5,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [LEN_W-1:0]      len,
  input  logic [1:0]            mode,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] data_masked,
  output par_flags_t            flags
);

  logic [LEN_W-1:0]      eff_len;
  logic [DATA_WIDTH-1:0] mask;

  always_comb begin
    eff_len = len;
    if (len < LEN_W'(MIN_WIDTH))       eff_len = LEN_W'(MIN_WIDTH);
    else if (len > LEN_W'(DATA_WIDTH)) eff_len = LEN_W'(DATA_WIDTH);
  end

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign mask[i] = (LEN_W'(i) < eff_len);
  end

  assign data_masked = data & mask;

  always_comb begin
    flags = '0;
    if (enable) begin
      flags.active = 1'b1;
      case (mode)
        PAR_EVEN: flags.parity = ^data_masked;
        PAR_ODD:  flags.parity = ~^data_masked;
        PAR_MARK: flags.parity = 1'b1;
        default:  flags.parity = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/tx_parity_engine.sv
// TX parity stage: parity computed at accept, then a 2-entry skid buffer toward the frame FSM.
module tx_parity_engine
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_WIDTH  = 5
) (
  input logic              CLK,
  input logic              RST,
  tx_parity_engine_if.slave bus
);

  localparam int LEN_W = $clog2(DATA_WIDTH + 1);

  typedef struct packed {
    par_flags_t            flags;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t state;
  entry_t head, skid, in_ent;
  logic   rdy_q, vld_q;
  logic   acc, ack;

  parity_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .MIN_WIDTH (MIN_WIDTH),
    .LEN_W     (LEN_W)
  ) u_par (
    .data       (bus.Parallel_Data),
    .len        (bus.Frame_Len),
    .mode       (bus.Parity_Mode),
    .enable     (bus.Parity_Enable),
    .data_masked(in_ent.data),
    .flags      (in_ent.flags)
  );

  assign acc = bus.Data_Valid && rdy_q;
  assign ack = bus.Out_Ack && vld_q;

  // Ready and valid are registered alongside the state so neither has a path from Out_Ack.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_EMPTY;
      head  <= '0;
      skid  <= '0;
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      case (state)
        S_EMPTY: begin
          rdy_q <= 1'b1;
          if (acc) begin
            head  <= in_ent;
            vld_q <= 1'b1;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          case ({acc, ack})
            2'b10: begin
              skid  <= in_ent;
              rdy_q <= 1'b0;
              state <= S_TWO;
            end
            2'b01: begin
              head  <= '0;
              vld_q <= 1'b0;
              state <= S_EMPTY;
            end
            2'b11: head <= in_ent;
            default: ;
          endcase
        end
        S_TWO: begin
          if (ack) begin
            head  <= skid;
            skid  <= '0;
            rdy_q <= 1'b1;
            state <= S_ONE;
          end
        end
        default: begin
          state <= S_EMPTY;
          vld_q <= 1'b0;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Data_Ready    = rdy_q;
  assign bus.Out_Valid     = vld_q;
  assign bus.Out_Data      = head.data;
  assign bus.Parity_Bit    = head.flags.parity;
  assign bus.Parity_Active = head.flags.active;

endmodule

// File: doc/tx_parity_engine.md
Name: tx_parity_engine

Overview:
- Next-generation parity stage for the UART transmit path.
- Accepts parallel words over a valid/ready handshake and snapshots the per-word configuration: enable, mode, frame length.
- Computes parity on a masked, length-limited word and presents {data, parity, active flag} to the TX frame FSM.
- Output side is a valid/ack interface behind a 2-entry skid buffer, so back-to-back words sustain one per cycle under backpressure.

Parameters:
- DATA_WIDTH, 8, maximum frame data bits; legal range 5..16.
- MIN_WIDTH, 5, minimum data bits per frame; shorter Frame_Len values are clamped up to this.
- LEN_W, $clog2(DATA_WIDTH+1), width of the Frame_Len field (derived; not overridden).

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- Parity_Enable  in  1  per-word enable; sampled on accept.
- Parity_Mode  in  2  per-word mode: 00 even, 01 odd, 10 mark (always 1), 11 space (always 0); sampled on accept.
- Frame_Len  in  LEN_W  number of data bits in the frame; sampled on accept.
- Data_Valid  in  1  input word valid.
- Parallel_Data  in  DATA_WIDTH  input word, LSB first on the line.
- Data_Ready  out  1  engine can accept a word this cycle.
- Out_Valid  out  1  output entry valid.
- Out_Ack  in  1  consumer takes the output entry this cycle.
- Out_Data  out  DATA_WIDTH  accepted word; bits at index >= effective length forced to 0.
- Parity_Bit  out  1  computed parity bit for the head entry.
- Parity_Active  out  1  head entry has parity enabled; TX FSM skips the parity slot when 0.

Behaviour:
- Reset: while RST is high at a clock edge, both entries are cleared.
  - Out_Valid=0, Out_Data=0, Parity_Bit=0, Parity_Active=0.
  - Data_Ready=0 while RST is high; Data_Ready=1 in the first cycle after RST deasserts.
- Accept: a word is taken when Data_Valid && Data_Ready at a rising edge.
  - Config is snapshotted at that same edge; later config changes never affect an accepted word.
  - Data_Valid while Data_Ready=0 is ignored. The producer holds the word; the engine never drops or duplicates it.
- Effective length L:
  - Frame_Len < MIN_WIDTH gives L = MIN_WIDTH.
  - Frame_Len > DATA_WIDTH gives L = DATA_WIDTH.
  - Otherwise L = Frame_Len.
  - Mask = (1<<L)-1.
- Parity is computed at accept time on the masked data and stored with the entry:
  - even = XOR of masked bits.
  - odd = inverse of even.
  - mark = 1.
  - space = 0.
  - Parity_Enable=0 gives Parity_Bit=0 and Parity_Active=0. The word still flows through.
- Latency: an accepted word appears on Out_* in the next cycle (1-cycle registered) when the buffer was empty.
- Buffer FSM states (count of valid entries):
  - EMPTY: Data_Ready=1, Out_Valid=0. Accept goes to ONE.
  - ONE: Data_Ready=1, Out_Valid=1.
    - Accept and no Out_Ack: go to TWO.
    - Out_Ack and no accept: go to EMPTY.
    - Accept and Out_Ack together: stay in ONE; the head is replaced by the new word.
  - TWO: Data_Ready=0, Out_Valid=1. Out_Ack moves the skid entry to the head and goes to ONE. No accept is possible.
- Data_Ready is a registered function of state: 1 in EMPTY/ONE, 0 in TWO and during reset. It has no combinational path from Out_Ack.
- Out_* hold stable while Out_Valid && !Out_Ack.
- Out_Ack while Out_Valid=0 is ignored; no state change.
- Ordering is strictly FIFO.
- Reset mid-operation discards both entries. There is no partial output in the cycle after.

Decomposition:
- Shared package uart_tx_pkg:
  - Parity_Mode encoding constants: PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE.
  - DATA_WIDTH limits.
  - Entry struct/concatenation layout {active, parity, data}.
- Sub-module parity_core: combinational masked-parity function (data, len, mode, enable -> parity, active). It is instantiated once at the input of the buffer. The buffer/FSM stays in the top module.

Test Plan:
- Reset release, then 0xA5, L=8, even, enable -> next cycle Out_Valid=1, Out_Data=0xA5, Parity_Bit=0, Parity_Active=1. Repeat with odd -> Parity_Bit=1.
- 0xFF, Frame_Len=5, even -> Out_Data=0x1F, Parity_Bit=1. Frame_Len=2 -> clamped to L=5, same result. Frame_Len=12 with DATA_WIDTH=8 -> L=8, Out_Data=0xFF, Parity_Bit=0.
- Mark/space/disabled on 0x00 -> Parity_Bit 1/0/0; Parity_Active 1/1/0.
- Out_Ack held low, three words 0x11, 0x22, 0x33 presented:
  - 0x11 and 0x22 are accepted; Data_Ready=0 after the second; 0x33 stalls.
  - Ack one per cycle -> outputs in order 0x11, 0x22, 0x33 with no gaps once 0x33 is accepted.
- Continuous Data_Valid with Out_Ack=1 -> one word per cycle; throughput 100%; state stays in ONE.
- Config change after accept: accept 0x01 odd, then switch mode to even while the word waits unacked -> Parity_Bit stays 0. Assert RST with two entries held -> next cycle Out_Valid=0, Data_Ready=0; the cycle after, Data_Ready=1.
